hist_reader: RTL and testbench
==============================

// Module: hist_reader
// PURPOSE
//  Read-side companion to the byte histogram. On a start pulse (the EOF strobe), scans all
//  bins through a 1-cycle-latency read port, skips zero bins, and streams (symbol, count)
//  pairs over a valid/ready handshake to the downstream tree builder.
//  Also reports the nonzero-bin count and the saturating total of all counts.
// PARAMETERS
//  NUM_BINS  256  number of histogram bins scanned (addresses 0..NUM_BINS-1)
//  SYM_W     8    symbol / bin address width
//  CNT_W     32   bin count width; also width of total
// PORTS
//  clk          in   1      clock; all logic on rising edge
//  rst          in   1      synchronous active-high reset
//  start        in   1      1-cycle pulse; begins a scan; ignored unless IDLE
//  rd_en        out  1      histogram read strobe
//  rd_addr      out  SYM_W  histogram read address
//  rd_data      in   CNT_W  bin count; valid the cycle after rd_en
//  out_valid    out  1      pair available
//  out_ready    in   1      consumer accepts pair when out_valid & out_ready
//  out_sym      out  SYM_W  symbol of current pair
//  out_cnt      out  CNT_W  count of current pair (never 0)
//  out_last     out  1      current pair is the final nonzero bin
//  busy         out  1      scan in progress
//  done         out  1      1-cycle pulse at scan completion
//  nonzero_bins out  SYM_W+1  number of nonzero bins found (0..NUM_BINS)
//  total        out  CNT_W  saturating sum of all bin counts
//  total_sat    out  1      total saturated during this scan
// BEHAVIOUR
//  - Reset (synchronous, any state): state IDLE; all outputs 0; pending reg P empty; idx 0.
//  - States: IDLE, SCAN, CHECK, EMIT, FLUSH, DONE.
//  - IDLE: on start -> SCAN, idx=0, clear total/total_sat/nonzero_bins/P. busy=1 from next cycle.
//  - SCAN: rd_en=1, rd_addr=idx for one cycle -> CHECK.
//  - CHECK: X=(idx,rd_data). If rd_data==0: drop. If !=0: nonzero_bins++, total+=rd_data
//    (saturate at 2^CNT_W-1, set total_sat sticky); if P empty P<=X else -> EMIT.
//    If not EMIT: idx==NUM_BINS-1 -> FLUSH when P valid, else DONE; otherwise idx++ -> SCAN.
//  - EMIT: out_valid=1 with P, out_last=0; hold until handshake; then P<=X;
//    idx==NUM_BINS-1 -> FLUSH else idx++ -> SCAN.
//  - FLUSH: out_valid=1 with P, out_last=1; on handshake P empty -> DONE.
//  - DONE: done=1 one cycle, busy=0 -> IDLE. nonzero_bins/total/total_sat hold until next start.
//  - One-entry lookahead P lets out_last mark the true final pair without a second pass.
//  - Handshake: once out_valid rises, out_sym/out_cnt/out_last stable and out_valid stays high
//    until accepted; out_valid never depends on out_ready. No reads issued during EMIT/FLUSH.
//  - Pairs emitted in ascending symbol order; each nonzero bin exactly once.
//  - Zero nonzero bins: no out_valid at all; done pulses, nonzero_bins=0, total=0.
//  - start while busy: ignored, scan unaffected. start and rst together: rst wins.
//  - Scan cost: 2 cycles/bin plus handshake stalls; min 2*NUM_BINS+2 cycles start->done.
// TESTING
//  1. Bins AB=2,CD=1,EF=3 else 0, out_ready=1 -> (AB,2,0),(CD,1,0),(EF,3,1); total=6, nonzero=3, one done.
//  2. All bins 0 -> out_valid never high; done pulse; nonzero_bins=0, total=0, total_sat=0.
//  3. Case 1 with out_ready low 5 cycles per pair -> payload stable while valid, same 3 pairs, no loss/dup.
//  4. Bins 00=1 and FF=7 only -> (00,1,0) then (FF,7,1); rd_addr reaches FF exactly once.
//  5. Bins 00,01 = FFFF_FFFF -> total=FFFF_FFFF, total_sat=1; next scan with small counts clears sat.
//  6. rst mid-EMIT -> next cycle all outputs 0, IDLE; start during busy -> ignored, results unchanged.

Source files
------------

// File: rtl/hist_reader_if.sv
// Histogram read port plus the (symbol, count) output stream of hist_reader.
// The master drives the read strobe and the stream; the slave returns read data and ready.
interface hist_reader_if #(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned CNT_W = 32
);
  logic             rd_en;
  logic [SYM_W-1:0] rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic [CNT_W-1:0] out_cnt;
  logic             out_last;

  modport master (
    output rd_en, rd_addr, out_valid, out_sym, out_cnt, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_sym, out_cnt, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/hist_reader.sv
// Scans all histogram bins after EOF, streams nonzero (symbol, count) pairs in ascending order,
// and reports the nonzero-bin count and saturating total. One-entry lookahead marks the last pair.
module hist_reader #(
  parameter int unsigned NUM_BINS = 256,
  parameter int unsigned SYM_W    = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  hist_reader_if.master      hist_if,
  output logic               busy_o,
  output logic               done_o,
  output logic [SYM_W:0]     nonzero_bins_o,
  output logic [CNT_W-1:0]   total_o,
  output logic               total_sat_o
);

  localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NUM_BINS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_CHECK, S_EMIT, S_FLUSH, S_DONE
  } state_e;

  state_e           state_q;
  logic [SYM_W-1:0] idx_q;
  logic             p_vld_q;
  logic [SYM_W-1:0] p_sym_q;
  logic [CNT_W-1:0] p_cnt_q;
  logic [SYM_W-1:0] x_sym_q;
  logic [CNT_W-1:0] x_cnt_q;

  logic             rd_en_q;
  logic [SYM_W-1:0] rd_addr_q;
  logic             out_valid_q;
  logic [SYM_W-1:0] out_sym_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_last_q;
  logic             busy_q;
  logic             done_q;
  logic [SYM_W:0]   nonzero_q;
  logic [CNT_W-1:0] total_q;
  logic             sat_q;

  logic [CNT_W:0]   sum_c;
  logic             nz_c;
  logic             is_last_c;
  logic [SYM_W-1:0] idx_inc_c;

  assign sum_c     = {1'b0, total_q} + {1'b0, hist_if.rd_data};
  assign nz_c      = (hist_if.rd_data != '0);
  assign is_last_c = (idx_q == LAST_IDX);
  assign idx_inc_c = idx_q + SYM_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      p_vld_q     <= 1'b0;
      p_sym_q     <= '0;
      p_cnt_q     <= '0;
      x_sym_q     <= '0;
      x_cnt_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      nonzero_q   <= '0;
      total_q     <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_SCAN;
            idx_q     <= '0;
            p_vld_q   <= 1'b0;
            nonzero_q <= '0;
            total_q   <= '0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end

        S_SCAN: begin
          rd_en_q <= 1'b0;
          state_q <= S_CHECK;
        end

        S_CHECK: begin
          if (nz_c) begin
            nonzero_q <= nonzero_q + (SYM_W + 1)'(1);
            if (sum_c[CNT_W]) begin
              total_q <= '1;
              sat_q   <= 1'b1;
            end else begin
              total_q <= sum_c[CNT_W-1:0];
            end
            if (!p_vld_q) begin
              p_vld_q <= 1'b1;
              p_sym_q <= idx_q;
              p_cnt_q <= hist_if.rd_data;
            end else begin
              // Pending pair goes out; the new bin waits in X until the handshake.
              x_sym_q     <= idx_q;
              x_cnt_q     <= hist_if.rd_data;
              out_valid_q <= 1'b1;
              out_sym_q   <= p_sym_q;
              out_cnt_q   <= p_cnt_q;
              out_last_q  <= 1'b0;
              state_q     <= S_EMIT;
            end
          end
          if (!(nz_c && p_vld_q)) begin
            if (is_last_c) begin
              if (p_vld_q || nz_c) begin
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
                out_sym_q   <= p_vld_q ? p_sym_q : idx_q;
                out_cnt_q   <= p_vld_q ? p_cnt_q : hist_if.rd_data;
                state_q     <= S_FLUSH;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            end else begin
              idx_q     <= idx_inc_c;
              rd_en_q   <= 1'b1;
              rd_addr_q <= idx_inc_c;
              state_q   <= S_SCAN;
            end
          end
        end

        S_EMIT: begin
          if (hist_if.out_ready) begin
            p_sym_q <= x_sym_q;
            p_cnt_q <= x_cnt_q;
            if (is_last_c) begin
              out_sym_q  <= x_sym_q;
              out_cnt_q  <= x_cnt_q;
              out_last_q <= 1'b1;
              state_q    <= S_FLUSH;
            end else begin
              out_valid_q <= 1'b0;
              idx_q       <= idx_inc_c;
              rd_en_q     <= 1'b1;
              rd_addr_q   <= idx_inc_c;
              state_q     <= S_SCAN;
            end
          end
        end

        S_FLUSH: begin
          if (hist_if.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            p_vld_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hist_if.rd_en     = rd_en_q;
  assign hist_if.rd_addr   = rd_addr_q;
  assign hist_if.out_valid = out_valid_q;
  assign hist_if.out_sym   = out_sym_q;
  assign hist_if.out_cnt   = out_cnt_q;
  assign hist_if.out_last  = out_last_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign nonzero_bins_o    = nonzero_q;
  assign total_o           = total_q;
  assign total_sat_o       = sat_q;

endmodule

// File: tb/tb_hist_reader.sv
// Scoreboard bench for hist_reader: directed bin images, expected pairs queued at stimulus time,
// a negedge monitor pops and compares on every accepted pair.
module tb_hist_reader;
  localparam int unsigned NUM_BINS = 256;
  localparam int unsigned SYM_W    = 8;
  localparam int unsigned CNT_W    = 32;

  typedef struct packed {
    logic [SYM_W-1:0] sym;
    logic [CNT_W-1:0] cnt;
    logic             last;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy;
  logic             done;
  logic [SYM_W:0]   nonzero_bins;
  logic [CNT_W-1:0] total;
  logic             total_sat;

  hist_reader_if #(.SYM_W(SYM_W), .CNT_W(CNT_W)) bus ();

  hist_reader #(.NUM_BINS(NUM_BINS), .SYM_W(SYM_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .hist_if        (bus),
    .busy_o         (busy),
    .done_o         (done),
    .nonzero_bins_o (nonzero_bins),
    .total_o        (total),
    .total_sat_o    (total_sat)
  );

  always #5 clk = ~clk;

  logic [CNT_W-1:0] mem [NUM_BINS];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int    n_chk = 0;
  int    n_fail = 0;
  pair_t exp_q[$];
  int    done_cnt = 0;
  int    ff_reads = 0;
  int    valid_cycles = 0;
  bit    stall_mode = 1'b0;
  int    wait_cnt = 0;
  bit    prev_hold = 1'b0;
  pair_t prev_pl;
  pair_t cur;
  pair_t exp_p;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Consumer ready: always high, or held low 5 cycles per offered pair.
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      bus.out_ready = 1'b1;
      wait_cnt = 0;
    end else if (bus.out_valid) begin
      if (wait_cnt >= 5) begin
        bus.out_ready = 1'b1;
        wait_cnt = 0;
      end else begin
        bus.out_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.out_ready = 1'b0;
      wait_cnt = 0;
    end
  end

  // Monitor: pair scoreboard and handshake stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (bus.rd_en && bus.rd_addr == 8'hFF) ff_reads++;
      if (bus.out_valid) valid_cycles++;
      cur = '{sym: bus.out_sym, cnt: bus.out_cnt, last: bus.out_last};
      if (prev_hold) begin
        chk("valid_held", 64'(bus.out_valid), 64'(1));
        if (bus.out_valid) chk("payload_stable", 64'(cur), 64'(prev_pl));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pair: got %0h expected none", cur);
        end else begin
          exp_p = exp_q.pop_front();
          chk("pair", 64'(cur), 64'(exp_p));
        end
        prev_hold = 1'b0;
      end else if (bus.out_valid) begin
        prev_hold = 1'b1;
        prev_pl   = cur;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < int'(NUM_BINS); i++) mem[i] = '0;
  endtask

  task automatic push(input logic [SYM_W-1:0] s, input logic [CNT_W-1:0] c, input logic l);
    exp_q.push_back('{sym: s, cnt: c, last: l});
  endtask

  task automatic load_case1();
    clear_mem();
    mem[8'hAB] = 32'd2;
    mem[8'hCD] = 32'd1;
    mem[8'hEF] = 32'd3;
    push(8'hAB, 32'd2, 1'b0);
    push(8'hCD, 32'd1, 1'b0);
    push(8'hEF, 32'd3, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},     64'(bus.rd_en), 64'(0));
    chk({tag, "_rd_addr"},   64'(bus.rd_addr), 64'(0));
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_out_sym"},   64'(bus.out_sym), 64'(0));
    chk({tag, "_out_cnt"},   64'(bus.out_cnt), 64'(0));
    chk({tag, "_out_last"},  64'(bus.out_last), 64'(0));
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_done"},      64'(done), 64'(0));
    chk({tag, "_nonzero"},   64'(nonzero_bins), 64'(0));
    chk({tag, "_total"},     64'(total), 64'(0));
    chk({tag, "_sat"},       64'(total_sat), 64'(0));
  endtask

  task automatic run_scan(input string tag, input int exp_nz, input logic [CNT_W-1:0] exp_tot,
                          input logic exp_sat, input bit mid_start);
    int cyc;
    done_cnt = 0;
    ff_reads = 0;
    valid_cycles = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'(1));
    if (mid_start) begin
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_cnt == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 20000 cycles", tag);
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    chk({tag, "_nonzero"}, 64'(nonzero_bins), 64'(exp_nz));
    chk({tag, "_total"}, 64'(total), 64'(exp_tot));
    chk({tag, "_sat"}, 64'(total_sat), 64'(exp_sat));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    int c;
    bus.out_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    // Three nonzero bins, consumer always ready.
    load_case1();
    run_scan("t1", 3, 32'd6, 1'b0, 1'b0);

    // All bins empty: no pairs at all.
    clear_mem();
    run_scan("t2", 0, 32'd0, 1'b0, 1'b0);
    chk("t2_no_valid", 64'(valid_cycles), 64'(0));

    // Same image with a slow consumer.
    stall_mode = 1'b1;
    load_case1();
    run_scan("t3", 3, 32'd6, 1'b0, 1'b0);
    stall_mode = 1'b0;

    // First and last address only.
    clear_mem();
    mem[8'h00] = 32'd1;
    mem[8'hFF] = 32'd7;
    push(8'h00, 32'd1, 1'b0);
    push(8'hFF, 32'd7, 1'b1);
    run_scan("t4", 2, 32'd8, 1'b0, 1'b0);
    chk("t4_ff_reads", 64'(ff_reads), 64'(1));

    // Saturation, then a clean scan (with a stray start mid-scan) clears it.
    clear_mem();
    mem[8'h00] = 32'hFFFF_FFFF;
    mem[8'h01] = 32'hFFFF_FFFF;
    push(8'h00, 32'hFFFF_FFFF, 1'b0);
    push(8'h01, 32'hFFFF_FFFF, 1'b1);
    run_scan("t5", 2, 32'hFFFF_FFFF, 1'b1, 1'b0);
    load_case1();
    run_scan("t5b", 3, 32'd6, 1'b0, 1'b1);

    // Reset while a pair is stalled in EMIT, with start asserted alongside reset.
    stall_mode = 1'b1;
    load_case1();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("t6_reached_emit", 64'(bus.out_valid), 64'(1));
    @(posedge clk); #1;
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    check_zero("t6_rst");
    rst   = 1'b0;
    start = 1'b0;
    stall_mode = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("t6_idle_after_rst", 64'(busy), 64'(0));
    load_case1();
    run_scan("t6b", 3, 32'd6, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
